// File: rtl/sd_spi_arb_pkg.sv
// Shared definitions for the SD SPI arbiter: FSM states, owner encoding, reset constants.
package sd_spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic       OWN_ZX   = 1'b0;
    localparam logic       OWN_AVR  = 1'b1;
    localparam logic [7:0] DOUT_RST = 8'hFF;

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode 0 byte shifter: half-period divider, 16-phase sdclk, MSB-first tx/rx.
module sd_spi_shifter #(
    parameter int DIV   = 2,
    parameter int DIV_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift_en,
    input  logic [7:0] din,
    input  logic       sddi,
    output logic       sdclk,
    output logic       sddo,
    output logic [7:0] rx,
    output logic       done
);

    localparam logic [DIV_W-1:0] HLAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] hcnt;
    logic [3:0]       phase;
    logic [7:0]       tx;
    logic             hstep;

    assign hstep = shift_en && (hcnt == HLAST);
    assign done  = hstep && (phase == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt  <= '0;
            phase <= '0;
            sdclk <= 1'b0;
            sddo  <= 1'b1;
            tx    <= 8'hFF;
            rx    <= 8'h00;
        end else if (load) begin
            hcnt  <= '0;
            phase <= '0;
            sdclk <= 1'b0;
            tx    <= din;
            sddo  <= din[7];
        end else if (shift_en) begin
            if (hstep) begin
                hcnt  <= '0;
                phase <= phase + 4'd1;
                sdclk <= ~sdclk;
                if (!sdclk) begin
                    rx <= {rx[6:0], sddi};
                end else begin
                    // ones shift in behind the data so MOSI idles high after the last bit
                    tx   <= {tx[6:0], 1'b1};
                    sddo <= tx[6];
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_spi_arb.sv
// SD-card SPI master shared between the AVR slave-SPI block and the Z80 port interface.
module sd_spi_arb
    import sd_spi_arb_pkg::*;
#(
    parameter int DIV   = 2,
    parameter int DIV_W = 4
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       avr_lock_req,
    input  logic       avr_cs_n,
    input  logic       avr_start,
    input  logic [7:0] avr_din,
    output logic       avr_lock_ack,
    output logic [7:0] avr_dout,
    input  logic       zx_cs_we,
    input  logic       zx_cs_val,
    input  logic       zx_start,
    input  logic [7:0] zx_din,
    output logic [7:0] zx_dout,
    output logic       busy,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sddi,
    output logic       sdcs_n
);

    state_t     state, state_nxt;
    logic       owner, client, zx_cs;
    logic       accept, shift_done;
    logic [7:0] load_din, rx;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (shift_done) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Starts are judged against the owner before any same-cycle ownership update.
    always_comb begin
        accept   = (state == ST_IDLE) && ((owner == OWN_AVR) ? avr_start : zx_start);
        load_din = (owner == OWN_AVR) ? avr_din : zx_din;
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= OWN_ZX;
            avr_lock_ack <= 1'b0;
            client       <= OWN_ZX;
            zx_cs        <= 1'b1;
            sdcs_n       <= 1'b1;
            busy         <= 1'b0;
            avr_dout     <= DOUT_RST;
            zx_dout      <= DOUT_RST;
        end else begin
            if (state == ST_IDLE) begin
                owner        <= avr_lock_req ? OWN_AVR : OWN_ZX;
                avr_lock_ack <= avr_lock_req;
            end
            if (accept) client <= owner;
            if (zx_cs_we) zx_cs <= zx_cs_val;
            sdcs_n <= (owner == OWN_AVR) ? avr_cs_n : zx_cs;
            busy   <= (state_nxt != ST_IDLE);
            if (state == ST_DONE) begin
                if (client == OWN_AVR) avr_dout <= rx;
                else                   zx_dout  <= rx;
            end
        end
    end

    sd_spi_shifter #(.DIV(DIV), .DIV_W(DIV_W)) u_shifter (
        .clk      (fclk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift_en (state == ST_SHIFT),
        .din      (load_din),
        .sddi     (sddi),
        .sdclk    (sdclk),
        .sddo     (sddo),
        .rx       (rx),
        .done     (shift_done)
    );

endmodule

// File: tb/tb_sd_spi_arb.sv
// Directed bench for sd_spi_arb: vector table plus hand sequences; DIV=2 main DUT, DIV=1 loopback DUT.
module tb_sd_spi_arb;

    logic fclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 fclk = ~fclk;

    logic       avr_lock_req = 0, avr_cs_n = 0, avr_start = 0, zx_cs_we = 0, zx_cs_val = 1, zx_start = 0;
    logic [7:0] avr_din = 0, zx_din = 0;
    logic       avr_lock_ack, busy, sdclk, sddo, sddi, sdcs_n;
    logic [7:0] avr_dout, zx_dout;

    logic       zx_start1 = 0, zero1 = 0, one1 = 1;
    logic [7:0] zx_din1 = 0, zero8 = 0;
    logic       avr_lock_ack1, busy1, sdclk1, sddo1, sdcs_n1;
    logic [7:0] avr_dout1, zx_dout1;

    sd_spi_arb #(.DIV(2), .DIV_W(4)) u_dut (
        .fclk(fclk), .rst_n(rst_n), .avr_lock_req(avr_lock_req), .avr_cs_n(avr_cs_n),
        .avr_start(avr_start), .avr_din(avr_din), .avr_lock_ack(avr_lock_ack), .avr_dout(avr_dout),
        .zx_cs_we(zx_cs_we), .zx_cs_val(zx_cs_val), .zx_start(zx_start), .zx_din(zx_din),
        .zx_dout(zx_dout), .busy(busy), .sdclk(sdclk), .sddo(sddo), .sddi(sddi), .sdcs_n(sdcs_n)
    );

    sd_spi_arb #(.DIV(1), .DIV_W(2)) u_dut1 (
        .fclk(fclk), .rst_n(rst_n), .avr_lock_req(zero1), .avr_cs_n(one1),
        .avr_start(zero1), .avr_din(zero8), .avr_lock_ack(avr_lock_ack1), .avr_dout(avr_dout1),
        .zx_cs_we(zero1), .zx_cs_val(one1), .zx_start(zx_start1), .zx_din(zx_din1),
        .zx_dout(zx_dout1), .busy(busy1), .sdclk(sdclk1), .sddo(sddo1), .sddi(sddo1), .sdcs_n(sdcs_n1)
    );

    // SD card model: presents MSB first, advances on falling sdclk
    logic [7:0] resp_sh = 8'hFF, resp_val = 8'hFF;
    logic       resp_load = 1'b0;
    always @(negedge sdclk or posedge resp_load) begin
        if (resp_load) resp_sh = resp_val;
        else           resp_sh = {resp_sh[6:0], 1'b1};
    end
    assign sddi = resp_sh[7];

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge fclk);
        #1;
    endtask

    task automatic load_resp(input logic [7:0] v);
        resp_val  = v;
        resp_load = 1'b1;
        #1;
        resp_load = 1'b0;
    endtask

    // Called on the sample right after the accepting edge; returns busy length and MOSI byte.
    task automatic wait_done(output int cyc, output logic [7:0] sent);
        logic prev;
        cyc  = 1;
        sent = 8'h00;
        prev = sdclk;
        while (busy && cyc < 200) begin
            tick;
            if (sdclk && !prev) sent = {sent[6:0], sddo};
            prev = sdclk;
            if (busy) cyc++;
        end
        if (busy) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic       lock, zs, as;
        logic [7:0] zd, ad, resp;
        logic       acc;
        logic [7:0] sent, ezx, eavr;
        logic       ecs;
    } vec_t;

    vec_t vt[6];

    initial begin
        int         cyc;
        logic [7:0] sent;
        logic [15:0] pat;

        vt[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 8'h3C, 1'b1, 8'hA5, 8'h3C, 8'hFF, 1'b1};
        vt[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 8'h00, 1'b0, 8'h00, 8'h3C, 8'hFF, 1'b1};
        vt[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h5A, 8'hC3, 1'b1, 8'h5A, 8'h3C, 8'hC3, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 8'h00, 1'b0, 8'h00, 8'h3C, 8'hC3, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h96, 1'b1, 8'hFF, 8'h3C, 8'h96, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 8'h7E, 8'h00, 8'h81, 1'b1, 8'h7E, 8'h81, 8'h96, 1'b1};

        repeat (3) tick;
        chk("rst_sdclk", sdclk, 1'b0);
        chk("rst_sddo", sddo, 1'b1);
        chk("rst_sdcs_n", sdcs_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", avr_lock_ack, 1'b0);
        chk("rst_zx_dout", zx_dout, 8'hFF);
        chk("rst_avr_dout", avr_dout, 8'hFF);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            avr_lock_req = vt[i].lock;
            tick;
            tick;
            chk($sformatf("v%0d_ack", i), avr_lock_ack, vt[i].lock);
            chk($sformatf("v%0d_sdcs_n", i), sdcs_n, vt[i].ecs);
            load_resp(vt[i].resp);
            zx_din    = vt[i].zd;
            avr_din   = vt[i].ad;
            zx_start  = vt[i].zs;
            avr_start = vt[i].as;
            tick;
            zx_start  = 1'b0;
            avr_start = 1'b0;
            chk($sformatf("v%0d_accept", i), busy, vt[i].acc);
            if (vt[i].acc) begin
                wait_done(cyc, sent);
                chk($sformatf("v%0d_busy_len", i), cyc, 33);
                chk($sformatf("v%0d_mosi", i), sent, vt[i].sent);
            end else begin
                repeat (40) tick;
            end
            chk($sformatf("v%0d_zx_dout", i), zx_dout, vt[i].ezx);
            chk($sformatf("v%0d_avr_dout", i), avr_dout, vt[i].eavr);
        end

        // lock requested mid Z80 transfer is granted only after DONE
        load_resp(8'h55);
        zx_din   = 8'h0F;
        zx_start = 1'b1;
        tick;
        zx_start = 1'b0;
        repeat (5) tick;
        avr_lock_req = 1'b1;
        tick;
        chk("lock_ack_mid", avr_lock_ack, 1'b0);
        wait_done(cyc, sent);
        chk("lock_ack_at_fall", avr_lock_ack, 1'b0);
        tick;
        chk("lock_ack_granted", avr_lock_ack, 1'b1);
        chk("lock_zx_dout", zx_dout, 8'h55);
        avr_cs_n = 1'b1;
        tick;
        tick;
        chk("cs_follow_avr_hi", sdcs_n, 1'b1);
        avr_cs_n = 1'b0;
        tick;
        tick;
        chk("cs_follow_avr_lo", sdcs_n, 1'b0);
        load_resp(8'h01);
        avr_din   = 8'hFF;
        avr_start = 1'b1;
        tick;
        avr_start = 1'b0;
        wait_done(cyc, sent);
        chk("lock_avr_mosi", sent, 8'hFF);
        chk("lock_avr_dout", avr_dout, 8'h01);

        // busy drops: mid-transfer start, start in DONE, start one cycle later
        avr_lock_req = 1'b0;
        tick;
        tick;
        load_resp(8'hA0);
        zx_din   = 8'hC6;
        zx_start = 1'b1;
        tick;
        for (int k = 1; k <= 32; k++) begin
            zx_start = (k == 10);
            tick;
        end
        chk("busy_before_fall", busy, 1'b1);
        load_resp(8'h24);
        zx_din   = 8'h3B;
        zx_start = 1'b1;
        tick;
        chk("start_on_fall_dropped", busy, 1'b0);
        chk("busy_zx_dout", zx_dout, 8'hA0);
        tick;
        zx_start = 1'b0;
        chk("start_after_fall", busy, 1'b1);
        wait_done(cyc, sent);
        chk("b2b_busy_len", cyc, 33);
        chk("b2b_mosi", sent, 8'h3B);
        chk("b2b_zx_dout", zx_dout, 8'h24);

        // reset at phase 7 aborts the transfer
        zx_cs_we  = 1'b1;
        zx_cs_val = 1'b0;
        tick;
        zx_cs_we  = 1'b0;
        tick;
        chk("zx_cs_low", sdcs_n, 1'b0);
        load_resp(8'h5A);
        zx_din   = 8'h99;
        zx_start = 1'b1;
        tick;
        zx_start = 1'b0;
        repeat (14) tick;
        chk("sdclk_pre_rst", sdclk, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sdclk", sdclk, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_sdcs_n", sdcs_n, 1'b1);
        chk("rst_mid_zx_dout", zx_dout, 8'hFF);
        chk("rst_mid_avr_dout", avr_dout, 8'hFF);
        tick;
        rst_n = 1'b1;
        repeat (40) tick;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_zx_dout", zx_dout, 8'hFF);
        load_resp(8'hC3);
        zx_din   = 8'h81;
        zx_start = 1'b1;
        tick;
        zx_start = 1'b0;
        wait_done(cyc, sent);
        chk("post_rst_busy_len", cyc, 33);
        chk("post_rst_mosi", sent, 8'h81);
        chk("post_rst_zx_dout", zx_dout, 8'hC3);

        // DIV=1 loopback build
        zx_din1   = 8'h81;
        zx_start1 = 1'b1;
        tick;
        zx_start1 = 1'b0;
        chk("div1_start", busy1, 1'b1);
        pat = '0;
        cyc = 1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            pat = {pat[14:0], sdclk1};
            if (busy1) cyc++;
        end
        chk("div1_sdclk_pattern", pat, 16'hAAAA);
        while (busy1 && cyc < 100) begin
            tick;
            if (busy1) cyc++;
        end
        chk("div1_busy_len", cyc, 17);
        chk("div1_loopback", zx_dout1, 8'h81);
        chk("div1_avr_dout", avr_dout1, 8'hFF);
        chk("div1_ack", avr_lock_ack1, 1'b0);
        chk("div1_sdcs_n", sdcs_n1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_spi_arb.md
Name: sd_spi_arb

Overview:
SD-card SPI master with two-client arbitration, directly downstream of the AVR slave-SPI block.
- Consumes that block's sd_lock_out / sd_cs_n / sd_start / sd_datain.
- Returns sd_lock_in / sd_dataout to it.
- Also serves the Z80 port-side SD interface.
- Drives the physical SD pins: one byte per start strobe, SPI mode 0, MSB first.

Parameters:
DIV, 2, SD clock half-period in fclk cycles (>=1); SD clock = fclk/(2*DIV)
DIV_W, 4, width of the half-period counter; must satisfy 2**DIV_W > DIV

Ports:
fclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
avr_lock_req  in  1  AVR requests exclusive SD ownership (from sd_lock_out)
avr_cs_n  in  1  AVR-side chip select value (from sd_cs_n)
avr_start  in  1  one-cycle AVR start strobe (from sd_start)
avr_din  in  8  AVR byte to send (from sd_datain)
avr_lock_ack  out  1  AVR currently owns the SD bus (to sd_lock_in)
avr_dout  out  8  last byte received for AVR (to sd_dataout)
zx_cs_we  in  1  one-cycle Z80 chip-select write strobe
zx_cs_val  in  1  Z80 chip-select value written on zx_cs_we
zx_start  in  1  one-cycle Z80 start strobe
zx_din  in  8  Z80 byte to send
zx_dout  out  8  last byte received for Z80
busy  out  1  transfer in progress
sdclk  out  1  SD clock
sddo  out  1  SD MOSI
sddi  in  1  SD MISO, already synchronous to fclk
sdcs_n  out  1  SD chip select

Behaviour:
- Reset values (async, on rst_n low):
  - sdclk=0, sddo=1, sdcs_n=1, busy=0, avr_lock_ack=0
  - avr_dout=8'hFF, zx_dout=8'hFF
  - Z80 cs register=1; owner=Z80; FSM=IDLE
- Reset mid-transfer aborts immediately: no dout update, sdclk returns to 0.
- Ownership:
  - owner register changes only in IDLE: owner <= avr_lock_req.
  - avr_lock_ack = (owner==AVR), registered.
  - A lock request arriving during SHIFT is granted on the first IDLE cycle after DONE.
  - Lock drop behaves the same way.
- sdcs_n = (owner==AVR) ? avr_cs_n : Z80 cs register, registered one fclk.
- zx_cs_we updates the Z80 cs register at any time, regardless of owner.
- Start acceptance:
  - In IDLE, only the owner's start is accepted; the non-owner's start is silently dropped.
  - Starts while busy are dropped from both sides.
  - An accepted start latches the owner's din into the shift register and records which client started.
- FSM states IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: start accepted at edge T0 → SHIFT. At T0: busy=1, sddo=din[7], half-counter=0, phase counter=0.
  - SHIFT: half-counter counts 0..DIV-1. On terminal count, sdclk toggles and phase counter (0..15) increments.
    - Rising sdclk edge: sample sddi into receive register LSB, shifting left.
    - Falling sdclk edge: shift transmit register left; sddo = next bit.
    - After the 16th toggle (sdclk back to 0) → DONE.
  - DONE (1 cycle): the starting client's dout <= receive register; busy=0; sddo=1 on that edge.
  - Exit DONE to IDLE, where owner re-evaluation happens.
- Latency: busy high for exactly 16*DIV+1 fclk cycles. Example: DIV=2 gives 33 cycles. New dout is visible on the cycle busy falls.
- First rising sdclk occurs DIV cycles after T0, giving MOSI DIV cycles of setup.
- Back-to-back: a start arriving in the cycle busy falls is dropped (FSM in DONE). A start one cycle later is accepted.
- Simultaneous avr_start and zx_start in IDLE: only the owner's start is taken.
- Simultaneous start and lock change in IDLE: the start is judged against the owner value before the update.
- A DIV=1 build must work: sdclk toggles every fclk cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SHIFT, DONE)
  - owner encoding (OWN_ZX=0, OWN_AVR=1)
  - reset constants (DOUT_RST=8'hFF)
- One natural sub-module, sd_spi_shifter: holds the half-period counter, phase counter, sdclk, tx/rx shift registers and done pulse. The parent keeps arbitration, cs muxing, ownership and dout registers.

Test Plan:
- Z80 owner, DIV=2, zx_start with zx_din=8'hA5, SD model returning 8'h3C:
  - sddo serialises 1,0,1,0,0,1,0,1 on sdclk rising edges.
  - zx_dout=8'h3C when busy falls, 33 cycles after start.
  - avr_dout stays 8'hFF.
- avr_lock_req=1 while a Z80 transfer is in progress:
  - avr_lock_ack rises only after that transfer's DONE.
  - Then avr_start with 8'hFF and SD returning 8'h01 gives avr_dout=8'h01.
  - sdcs_n follows avr_cs_n.
- Ownership and collision: avr_start while Z80 owns is ignored (busy stays 0). Simultaneous zx_start/avr_start with AVR owner → only avr_din is sent.
- Busy behaviour:
  - A start while busy is dropped.
  - A start on the busy-falling cycle is dropped.
  - A start on the following cycle is accepted.
- Assert rst_n low at phase 7 of a transfer: sdclk=0, sdcs_n=1, busy=0 immediately. Douts keep their reset value 8'hFF, and a subsequent transfer works normally.
- DIV=1 build, byte 8'h81 sent: sdclk period is 2 fclk; busy is 17 cycles; loopback (sddi=sddo) returns 8'h81.
